// File: rtl/wb_regfile_slave.sv
// Wishbone classic slave exposing a bank of byte-writable registers.
// Each request is latched when accepted, optionally delayed by a fixed
// number of wait states, then answered with ack (valid index) or err
// (index beyond the register bank). The termination stays asserted
// until the master drops its strobe or cycle.

module wb_regfile_slave #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 8,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      cyc_i,
   input  logic                      stb_i,
   input  logic                      we_i,
   input  logic [ADDR_WIDTH-1:0]     adr_i,
   input  logic [DATA_WIDTH/8-1:0]   sel_i,
   input  logic [DATA_WIDTH-1:0]     dat_i,
   output logic [DATA_WIDTH-1:0]     dat_o,
   output logic                      ack_o,
   output logic                      err_o
);

   localparam int NumLanes = DATA_WIDTH / 8;
   localparam int IdxWidth = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   // One extra bit so that NUM_REGS == 2**ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0] RegLimit = (ADDR_WIDTH + 1)'(NUM_REGS);

   // Counter preload on acceptance; the WAIT state spends one edge per
   // count plus the final edge that performs the access.
   localparam logic [3:0] WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              waitCnt_q, waitCnt_d;
   logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
   logic                    we_q, we_d;
   logic [NumLanes-1:0]     sel_q, sel_d;
   logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
   logic                    ack_q, ack_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;

   logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

   logic                    busReq;
   logic                    doAccess;
   logic [ADDR_WIDTH-1:0]   accAdr;
   logic                    accWe;
   logic [NumLanes-1:0]     accSel;
   logic [DATA_WIDTH-1:0]   accDat;
   logic                    accInRange;
   logic [IdxWidth-1:0]     accIdx;
   logic                    regWrEn;

   assign busReq     = cyc_i & stb_i;
   assign accInRange = ({1'b0, accAdr} < RegLimit);
   assign accIdx     = accAdr[IdxWidth-1:0];
   assign regWrEn    = doAccess & accWe & accInRange;

   // Next-state logic: request acceptance, wait countdown, abort and
   // response hold. The access operands come straight from the bus when
   // there are no wait states, otherwise from the latched copies.
   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      adr_d     = adr_q;
      we_d      = we_q;
      sel_d     = sel_q;
      wdat_d    = wdat_q;
      ack_d     = ack_q;
      err_d     = err_q;
      rdat_d    = rdat_q;
      doAccess  = 1'b0;
      accAdr    = adr_q;
      accWe     = we_q;
      accSel    = sel_q;
      accDat    = wdat_q;

      case (state_q)
         IDLE: begin
            if (busReq) begin
               adr_d  = adr_i;
               we_d   = we_i;
               sel_d  = sel_i;
               wdat_d = dat_i;
               if (WAIT_STATES == 0) begin
                  state_d  = RESP;
                  doAccess = 1'b1;
                  accAdr   = adr_i;
                  accWe    = we_i;
                  accSel   = sel_i;
                  accDat   = dat_i;
               end else begin
                  state_d   = WAIT;
                  waitCnt_d = WaitLoad;
               end
            end
         end

         WAIT: begin
            if (!cyc_i) begin
               state_d   = IDLE;
               waitCnt_d = 4'd0;
            end else if (waitCnt_q != 4'd0) begin
               waitCnt_d = waitCnt_q - 4'd1;
            end else begin
               state_d  = RESP;
               doAccess = 1'b1;
            end
         end

         RESP: begin
            if (!busReq) begin
               state_d = IDLE;
               ack_d   = 1'b0;
               err_d   = 1'b0;
            end
         end

         default: begin
            state_d   = IDLE;
            waitCnt_d = 4'd0;
            ack_d     = 1'b0;
            err_d     = 1'b0;
         end
      endcase

      if (doAccess) begin
         ack_d = accInRange;
         err_d = ~accInRange;
         if (!accWe) begin
            rdat_d = accInRange ? regs_q[accIdx] : '0;
         end
      end
   end

   // Control and response state, cleared immediately by reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         waitCnt_q <= 4'd0;
         adr_q     <= '0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         wdat_q    <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         rdat_q    <= '0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         adr_q     <= adr_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         wdat_q    <= wdat_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         rdat_q    <= rdat_d;
      end
   end

   // Register bank: byte-lane writes on a valid write access only.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= '0;
         end
      end else if (regWrEn) begin
         for (int b = 0; b < NumLanes; b++) begin
            if (accSel[b]) begin
               regs_q[accIdx][b*8 +: 8] <= accDat[b*8 +: 8];
            end
         end
      end
   end

   // Terminations are gated by the live bus so they drop in the same
   // cycle the master releases the strobe or cycle.
   assign dat_o = rdat_q;
   assign ack_o = ack_q & busReq;
   assign err_o = err_q & busReq;

endmodule

// File: tb/tb_wb_regfile_slave.sv
// Self-checking bench for wb_regfile_slave: a table of directed transfers,
// a randomized phase against a register-array model, and hand-written
// sequences for abort, held response, mid-transfer reset and zero wait states.

module tb_wb_regfile_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic        weS;
   logic [7:0]  adrS;
   logic [3:0]  selS;
   logic [31:0] datS;
   logic        cycA, stbA, cycB, stbB;
   logic [31:0] datOA, datOB;
   logic        ackA, errA, ackB, errB;

   int total = 0;
   int bad   = 0;

   logic [31:0] model [16];
   logic [31:0] lastDat;

   typedef struct {
      logic        we;
      logic [7:0]  adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic        expAck;
      logic        expErr;
      logic [31:0] expDat;
   } vec_t;

   vec_t vecs [8];

   always #5 clk = ~clk;

   wb_regfile_slave #(
      .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(16), .WAIT_STATES(2)
   ) dutA (
      .clk_i(clk), .rst_i(rst), .cyc_i(cycA), .stb_i(stbA), .we_i(weS),
      .adr_i(adrS), .sel_i(selS), .dat_i(datS),
      .dat_o(datOA), .ack_o(ackA), .err_o(errA)
   );

   wb_regfile_slave #(
      .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(16), .WAIT_STATES(0)
   ) dutB (
      .clk_i(clk), .rst_i(rst), .cyc_i(cycB), .stb_i(stbB), .we_i(weS),
      .adr_i(adrS), .sel_i(selS), .dat_i(datS),
      .dat_o(datOB), .ack_o(ackB), .err_o(errB)
   );

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   // One full transfer: drive at the current negedge, wait for the
   // termination (bounded), then release the bus and let one edge pass.
   task automatic applyStimulus(input bit fast, input logic we, input logic [7:0] adr,
                                input logic [3:0] sel, input logic [31:0] dat,
                                output logic [31:0] rdat, output logic ack,
                                output logic err, output int lat);
      weS = we; adrS = adr; selS = sel; datS = dat;
      if (fast) begin cycB = 1'b1; stbB = 1'b1; end
      else      begin cycA = 1'b1; stbA = 1'b1; end
      @(posedge clk);
      lat = 0; ack = 1'b0; err = 1'b0; rdat = '0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) begin
            adrS = 8'($urandom); datS = $urandom; selS = 4'($urandom); weS = 1'($urandom);
         end
         if ((fast ? (ackB | errB) : (ackA | errA)) === 1'b1) begin
            lat  = k;
            ack  = fast ? ackB : ackA;
            err  = fast ? errB : errA;
            rdat = fast ? datOB : datOA;
            break;
         end
      end
      cycA = 1'b0; stbA = 1'b0; cycB = 1'b0; stbB = 1'b0;
      @(posedge clk);
   endtask

   function automatic logic [31:0] laneMask(input logic [3:0] sel);
      logic [31:0] m = '0;
      for (int b = 0; b < 4; b++) if (sel[b]) m = m | (32'hFF << (8 * b));
      return m;
   endfunction

   // Reference behaviour: in-range index -> ack, else err; writes merge
   // enabled bytes; reads return the register or zero; writes keep dat_o.
   task automatic modelAccess(input logic we, input logic [7:0] adr, input logic [3:0] sel,
                              input logic [31:0] dat, output logic expAck,
                              output logic expErr, output logic [31:0] expDat);
      expAck = (adr < 16);
      expErr = !expAck;
      if (we) begin
         if (expAck) model[adr[3:0]] = (model[adr[3:0]] & ~laneMask(sel)) | (dat & laneMask(sel));
      end else begin
         lastDat = expAck ? model[adr[3:0]] : 32'h0;
      end
      expDat = lastDat;
   endtask

   task automatic modelReset();
      for (int i = 0; i < 16; i++) model[i] = '0;
      lastDat = '0;
   endtask

   task automatic checkedXfer(input string name, input logic we, input logic [7:0] adr,
                              input logic [3:0] sel, input logic [31:0] dat);
      logic [31:0] rd, ed;
      logic a, e, ea, ee;
      int lat;
      modelAccess(we, adr, sel, dat, ea, ee, ed);
      @(negedge clk);
      applyStimulus(1'b0, we, adr, sel, dat, rd, a, e, lat);
      checkOutput({name, "_ack"}, 32'(a), 32'(ea));
      checkOutput({name, "_err"}, 32'(e), 32'(ee));
      checkOutput({name, "_lat"}, 32'(lat), 32'd3);
      checkOutput({name, "_dat"}, rd, ed);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] rd, ed;
      logic a, e, ea, ee, any;
      int lat;

      vecs[0] = '{1'b0, 8'd3,  4'hF, 32'h0,        1'b1, 1'b0, 32'h00000000};
      vecs[1] = '{1'b1, 8'd5,  4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h00000000};
      vecs[2] = '{1'b1, 8'd5,  4'h5, 32'h11223344, 1'b1, 1'b0, 32'h00000000};
      vecs[3] = '{1'b0, 8'd5,  4'h0, 32'h0,        1'b1, 1'b0, 32'hDE22BE44};
      vecs[4] = '{1'b1, 8'd16, 4'hF, 32'hCAFEF00D, 1'b0, 1'b1, 32'hDE22BE44};
      vecs[5] = '{1'b0, 8'd16, 4'hF, 32'h0,        1'b0, 1'b1, 32'h00000000};
      vecs[6] = '{1'b0, 8'd5,  4'hF, 32'h0,        1'b1, 1'b0, 32'hDE22BE44};
      vecs[7] = '{1'b0, 8'd15, 4'hF, 32'h0,        1'b1, 1'b0, 32'h00000000};

      rst = 1'b1; cycA = 0; stbA = 0; cycB = 0; stbB = 0;
      weS = 0; adrS = 0; selS = 0; datS = 0;
      modelReset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_dat", datOA, 32'h0);
      checkOutput("reset_ack", 32'(ackA), 32'd0);
      checkOutput("reset_err", 32'(errA), 32'd0);

      // Release reset and present the first request in the same cycle.
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) @(negedge clk);
         applyStimulus(1'b0, vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, rd, a, e, lat);
         modelAccess(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, ea, ee, ed);
         checkOutput($sformatf("vec%0d_ack", i), 32'(a), 32'(vecs[i].expAck));
         checkOutput($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].expErr));
         checkOutput($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
         checkOutput($sformatf("vec%0d_dat", i), rd, vecs[i].expDat);
      end

      for (int i = 0; i < 40; i++) begin
         checkedXfer($sformatf("rnd%0d", i), 1'($urandom), 8'($urandom_range(0, 19)),
                     4'($urandom), $urandom);
      end

      // Abort: cycle dropped while waiting -> no termination, no write.
      checkedXfer("abort_pre", 1'b1, 8'd7, 4'hF, 32'h0BADF00D);
      @(negedge clk);
      weS = 1'b1; adrS = 8'd7; selS = 4'hF; datS = 32'h12345678;
      cycA = 1'b1; stbA = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cycA = 1'b0;
      any = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         any = any | ackA | errA;
      end
      checkOutput("abort_noterm", 32'(any), 32'd0);
      stbA = 1'b0;
      checkedXfer("abort_rd7", 1'b0, 8'd7, 4'hF, 32'h0);

      // Held response: ack stays up, no re-access, drops with stb.
      @(negedge clk);
      weS = 1'b1; adrS = 8'd2; selS = 4'hF; datS = 32'h1;
      cycA = 1'b1; stbA = 1'b1;
      modelAccess(1'b1, 8'd2, 4'hF, 32'h1, ea, ee, ed);
      @(posedge clk);
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (ackA === 1'b1) begin lat = k; break; end
      end
      checkOutput("hold_lat", 32'(lat), 32'd3);
      any = 1'b1;
      for (int k = 0; k < 5; k++) begin
         adrS = 8'd3; datS = 32'hFFFFFFFF; weS = 1'b1;
         @(negedge clk);
         any = any & ackA;
      end
      checkOutput("hold_ack", 32'(any), 32'd1);
      stbA = 1'b0;
      #1;
      checkOutput("hold_drop", 32'(ackA), 32'd0);
      @(posedge clk);
      @(negedge clk);
      cycA = 1'b0;
      checkedXfer("hold_rd2", 1'b0, 8'd2, 4'hF, 32'h0);
      checkedXfer("hold_rd3", 1'b0, 8'd3, 4'hF, 32'h0);

      // Reset during a write: discarded, registers cleared at once.
      checkedXfer("rst_pre", 1'b1, 8'd5, 4'hF, 32'hA1B2C3D4);
      checkedXfer("rst_pre_rd", 1'b0, 8'd5, 4'hF, 32'h0);
      @(negedge clk);
      weS = 1'b1; adrS = 8'd9; selS = 4'hF; datS = 32'hAAAA5555;
      cycA = 1'b1; stbA = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checkOutput("rst_async_dat", datOA, 32'h0);
      checkOutput("rst_async_ack", 32'({ackA, errA}), 32'd0);
      modelReset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rst_first_edge", 32'({ackA, errA}), 32'd0);
      @(negedge clk);
      cycA = 1'b0; stbA = 1'b0;
      checkedXfer("rst_rd9", 1'b0, 8'd9, 4'hF, 32'h0);
      checkedXfer("rst_rd5", 1'b0, 8'd5, 4'hF, 32'h0);

      // Zero wait states: termination one edge after acceptance.
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 8'd0, 4'hF, 32'h0, rd, a, e, lat);
      checkOutput("fast_rd0_lat", 32'(lat), 32'd1);
      checkOutput("fast_rd0_ack", 32'({a, e}), 32'b10);
      checkOutput("fast_rd0_dat", rd, 32'h0);
      @(negedge clk);
      applyStimulus(1'b1, 1'b1, 8'd1, 4'h3, 32'h5A5AA5A5, rd, a, e, lat);
      checkOutput("fast_wr1_lat", 32'(lat), 32'd1);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 8'd1, 4'hF, 32'h0, rd, a, e, lat);
      checkOutput("fast_rd1_dat", rd, 32'h0000A5A5);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 8'd20, 4'hF, 32'h0, rd, a, e, lat);
      checkOutput("fast_rd20_err", 32'({a, e}), 32'b01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
